// File: rtl/lii_stream_wrapper_gen.sv
// lii_stream_wrapper_gen: LII phy <-> HLS kernel stream adapter.
// Unpacks PW-bit beats into KW-bit kernel words and packs kernel words into tagged, FIFO-buffered PW-bit beats.
module lii_stream_wrapper_gen #(
   parameter int          PW           = 128,
   parameter int          KW           = 32,
   parameter logic [7:0]  LOCAL_ID     = 8'h00,
   parameter logic [7:0]  DST_ID       = 8'h01,
   parameter bit          REPLY_TO_SRC = 1'b0,
   parameter int          OBUF_DEPTH   = 4,
   localparam int         R            = PW / KW
) (
   input  logic              aclk,
   input  logic              arst,
   input  logic [PW-1:0]     lii_in_p0_tdata,
   input  logic              lii_in_p0_tvalid,
   output logic              lii_in_p0_tready,
   input  logic [7:0]        lii_in_p0_src,
   input  logic [7:0]        lii_in_p0_dst,
   output logic [PW-1:0]     lii_out_p0_tdata,
   output logic [R-1:0]      lii_out_p0_tkeep,
   output logic              lii_out_p0_tvalid,
   input  logic              lii_out_p0_tready,
   output logic [7:0]        lii_out_p0_src,
   output logic [7:0]        lii_out_p0_dst,
   output logic [KW-1:0]     in_stream_tdata,
   output logic              in_stream_tvalid,
   input  logic              in_stream_tready,
   input  logic [KW-1:0]     out_stream_tdata,
   input  logic              out_stream_tvalid,
   input  logic              out_stream_tlast,
   output logic              out_stream_tready,
   output logic              ce,
   output logic [15:0]       drop_cnt
);
   localparam int IW = R > 1 ? $clog2(R) : 1;
   localparam int AW = $clog2(OBUF_DEPTH);
   localparam int CW = AW + 1;

   logic                   run;
   logic [R-1:0][KW-1:0]   ibuf, acc, push_d;
   logic [R-1:0]           push_k;
   logic                   ibuf_valid;
   logic [IW-1:0]          idx, cnt;
   logic [7:0]             src_q;
   logic [R-1:0][KW-1:0]   mem_d [OBUF_DEPTH];
   logic [R-1:0]           mem_k [OBUF_DEPTH];
   logic [AW-1:0]          wp, rp;
   logic [CW-1:0]          count;
   logic                   in_hs, match, k_hs, k_last, o_hs, push, pop, full;

   // run holds the ready/enable outputs low until the first edge after reset release
   assign k_last            = idx == IW'(R - 1);
   assign lii_in_p0_tready  = run & (!ibuf_valid | (k_last & in_stream_tready));
   assign in_hs             = lii_in_p0_tvalid & lii_in_p0_tready;
   assign match             = lii_in_p0_dst == LOCAL_ID;
   assign in_stream_tvalid  = ibuf_valid;
   assign in_stream_tdata   = ibuf[idx];
   assign k_hs              = ibuf_valid & in_stream_tready;
   assign full              = count == CW'(OBUF_DEPTH);
   assign out_stream_tready = run & !full;
   assign o_hs              = out_stream_tvalid & out_stream_tready;
   assign push              = o_hs & ((cnt == IW'(R - 1)) | out_stream_tlast);
   assign lii_out_p0_tvalid = count != '0;
   assign pop               = lii_out_p0_tvalid & lii_out_p0_tready;
   assign lii_out_p0_tdata  = mem_d[rp];
   assign lii_out_p0_tkeep  = mem_k[rp];
   assign lii_out_p0_src    = LOCAL_ID;
   assign lii_out_p0_dst    = REPLY_TO_SRC ? src_q : DST_ID;

   // acc is cleared on every push, so words above cnt are already zero
   always_comb begin
      push_d      = acc;
      push_k      = '0;
      push_d[cnt] = out_stream_tdata;
      for (int i = 0; i < R; i++) push_k[i] = IW'(i) <= cnt;
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         run        <= 1'b0;
         ce         <= 1'b0;
         ibuf       <= '0;
         ibuf_valid <= 1'b0;
         idx        <= '0;
         src_q      <= '0;
         drop_cnt   <= '0;
         acc        <= '0;
         cnt        <= '0;
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
      end else begin
         run <= 1'b1;
         ce  <= count < CW'(OBUF_DEPTH - 1);
         if (in_hs && match) begin
            ibuf       <= lii_in_p0_tdata;
            ibuf_valid <= 1'b1;
            idx        <= '0;
            src_q      <= lii_in_p0_src;
         end else if (k_hs) begin
            ibuf_valid <= !k_last;
            idx        <= k_last ? '0 : idx + 1'b1;
         end
         if (in_hs && !match && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (o_hs) begin
            acc <= push ? '0 : push_d;
            cnt <= push ? '0 : cnt + 1'b1;
         end
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         mem_d[wp] <= push_d;
         mem_k[wp] <= push_k;
      end
   end
endmodule

// File: tb/tb_lii_stream_wrapper_gen.sv
// tb_lii_stream_wrapper_gen: directed vector bench for lii_stream_wrapper_gen (PW=128, KW=32, depth 4).
module tb_lii_stream_wrapper_gen;
   logic         clk = 1'b0, arst = 1'b1;
   logic [127:0] lii_in_p0_tdata = '0;
   logic         lii_in_p0_tvalid = 1'b0, lii_in_p0_tready;
   logic [7:0]   lii_in_p0_src = '0, lii_in_p0_dst = '0;
   logic [127:0] lii_out_p0_tdata;
   logic [3:0]   lii_out_p0_tkeep;
   logic         lii_out_p0_tvalid, lii_out_p0_tready = 1'b0;
   logic [7:0]   lii_out_p0_src, lii_out_p0_dst;
   logic [31:0]  in_stream_tdata;
   logic         in_stream_tvalid, in_stream_tready = 1'b0;
   logic [31:0]  out_stream_tdata = '0;
   logic         out_stream_tvalid = 1'b0, out_stream_tlast = 1'b0, out_stream_tready;
   logic         ce;
   logic [15:0]  drop_cnt;
   int           n_vec = 0, n_fail = 0;

   always #5 clk = ~clk;

   lii_stream_wrapper_gen dut (
      .aclk(clk), .arst(arst),
      .lii_in_p0_tdata(lii_in_p0_tdata), .lii_in_p0_tvalid(lii_in_p0_tvalid),
      .lii_in_p0_tready(lii_in_p0_tready), .lii_in_p0_src(lii_in_p0_src), .lii_in_p0_dst(lii_in_p0_dst),
      .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tkeep(lii_out_p0_tkeep),
      .lii_out_p0_tvalid(lii_out_p0_tvalid), .lii_out_p0_tready(lii_out_p0_tready),
      .lii_out_p0_src(lii_out_p0_src), .lii_out_p0_dst(lii_out_p0_dst),
      .in_stream_tdata(in_stream_tdata), .in_stream_tvalid(in_stream_tvalid),
      .in_stream_tready(in_stream_tready), .out_stream_tdata(out_stream_tdata),
      .out_stream_tvalid(out_stream_tvalid), .out_stream_tlast(out_stream_tlast),
      .out_stream_tready(out_stream_tready), .ce(ce), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [127:0]     data;
      logic [7:0]       dst;
      logic [7:0]       src;
      logic [0:3][31:0] ew;
      logic [15:0]      edrop;
   } uvec_t;

   typedef struct {
      int               n;
      bit               tl;
      logic [0:3][31:0] w;
      logic [127:0]     ebeat;
      logic [3:0]       ekeep;
   } pvec_t;

   uvec_t uv[4];
   pvec_t pv[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_in_ready();
      int t = 0;
      while (!lii_in_p0_tready && t < 20) begin
         step();
         t++;
      end
      chk("in_ready_wait", 128'(lii_in_p0_tready), 128'd1);
   endtask

   task automatic wait_k_ready();
      int t = 0;
      while (!out_stream_tready && t < 20) begin
         step();
         t++;
      end
      chk("k_ready_wait", 128'(out_stream_tready), 128'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit last);
      out_stream_tdata  = w;
      out_stream_tlast  = last;
      out_stream_tvalid = 1'b1;
      wait_k_ready();
      step();
      out_stream_tvalid = 1'b0;
      out_stream_tlast  = 1'b0;
   endtask

   initial begin
      logic [0:7][31:0] bw;
      logic [0:4][31:0] q;
      bit               acc_now;
      uv[0] = '{128'h33333333_22222222_11111111_00000000, 8'h00, 8'h05,
                {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333}, 16'd0};
      uv[1] = '{128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 8'h7F, 8'h09, '0, 16'd1};
      uv[2] = '{128'h89ABCDEF_01234567_CAFEBABE_12345678, 8'h00, 8'h22,
                {32'h12345678, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF}, 16'd1};
      uv[3] = '{128'h55555555_66666666_77777777_88888888, 8'h01, 8'h33, '0, 16'd2};
      pv[0] = '{4, 1'b0, {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004},
                128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 4'hF};
      pv[1] = '{2, 1'b1, {32'h0000CAFE, 32'h0000BEEF, 32'h0, 32'h0},
                128'h00000000_00000000_0000BEEF_0000CAFE, 4'h3};
      pv[2] = '{1, 1'b1, {32'h12121212, 32'h0, 32'h0, 32'h0},
                128'h00000000_00000000_00000000_12121212, 4'h1};
      pv[3] = '{4, 1'b1, {32'hE0E0E0E0, 32'hF1F1F1F1, 32'h02020202, 32'h13131313},
                128'h13131313_02020202_F1F1F1F1_E0E0E0E0, 4'hF};
      bw = {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
            32'h12345678, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF};
      q  = {32'hF0000000, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004};

      // reset state
      step();
      step();
      chk("rst_in_tready", 128'(lii_in_p0_tready), 128'd0);
      chk("rst_k_tready", 128'(out_stream_tready), 128'd0);
      chk("rst_ce", 128'(ce), 128'd0);
      chk("rst_out_tvalid", 128'(lii_out_p0_tvalid), 128'd0);
      chk("rst_in_stream_tvalid", 128'(in_stream_tvalid), 128'd0);
      chk("rst_drop", 128'(drop_cnt), 128'd0);
      arst = 1'b0;
      chk("rel_in_tready_low", 128'(lii_in_p0_tready), 128'd0);
      step();
      chk("rel_in_tready", 128'(lii_in_p0_tready), 128'd1);
      chk("rel_k_tready", 128'(out_stream_tready), 128'd1);
      chk("rel_ce", 128'(ce), 128'd1);

      // unpack table
      in_stream_tready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         lii_in_p0_tdata  = uv[v].data;
         lii_in_p0_dst    = uv[v].dst;
         lii_in_p0_src    = uv[v].src;
         lii_in_p0_tvalid = 1'b1;
         wait_in_ready();
         step();
         lii_in_p0_tvalid = 1'b0;
         if (uv[v].dst == 8'h00)
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("u%0d_valid%0d", v, k), 128'(in_stream_tvalid), 128'd1);
               chk($sformatf("u%0d_word%0d", v, k), 128'(in_stream_tdata), 128'(uv[v].ew[k]));
               step();
            end
         chk($sformatf("u%0d_idle", v), 128'(in_stream_tvalid), 128'd0);
         chk($sformatf("u%0d_drop", v), 128'(drop_cnt), 128'(uv[v].edrop));
      end

      // back-to-back beats with one kernel stall
      lii_in_p0_tdata  = uv[0].data;
      lii_in_p0_dst    = 8'h00;
      lii_in_p0_tvalid = 1'b1;
      step();
      lii_in_p0_tdata  = uv[2].data;
      for (int k = 0; k < 8; k++) begin
         if (k == 1) begin
            in_stream_tready = 1'b0;
            step();
            chk("b2b_stall_hold", 128'(in_stream_tdata), 128'(bw[1]));
            in_stream_tready = 1'b1;
         end
         chk($sformatf("b2b_valid%0d", k), 128'(in_stream_tvalid), 128'd1);
         chk($sformatf("b2b_word%0d", k), 128'(in_stream_tdata), 128'(bw[k]));
         if (k < 4) chk($sformatf("b2b_in_tready%0d", k), 128'(lii_in_p0_tready), 128'(k == 3));
         step();
         if (k == 3) lii_in_p0_tvalid = 1'b0;
      end
      chk("b2b_idle", 128'(in_stream_tvalid), 128'd0);

      // drop counter saturation
      lii_in_p0_dst    = 8'h7F;
      lii_in_p0_tvalid = 1'b1;
      repeat (70000) step();
      lii_in_p0_tvalid = 1'b0;
      chk("drop_sat", 128'(drop_cnt), 128'hFFFF);
      chk("drop_no_kernel", 128'(in_stream_tvalid), 128'd0);

      // pack table
      lii_out_p0_tready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < pv[v].n; i++) send_word(pv[v].w[i], pv[v].tl && i == pv[v].n - 1);
         chk($sformatf("p%0d_valid", v), 128'(lii_out_p0_tvalid), 128'd1);
         chk($sformatf("p%0d_data", v), lii_out_p0_tdata, pv[v].ebeat);
         chk($sformatf("p%0d_keep", v), 128'(lii_out_p0_tkeep), 128'(pv[v].ekeep));
         chk($sformatf("p%0d_src", v), 128'(lii_out_p0_src), 128'h00);
         chk($sformatf("p%0d_dst", v), 128'(lii_out_p0_dst), 128'h01);
         step();
         chk($sformatf("p%0d_drained", v), 128'(lii_out_p0_tvalid), 128'd0);
      end

      // output back-pressure, ce and full
      lii_out_p0_tready = 1'b0;
      for (int k = 0; k < 3; k++) send_word(q[k], 1'b1);
      step();
      chk("bp_ce_low3", 128'(ce), 128'd0);
      chk("bp_k_tready3", 128'(out_stream_tready), 128'd1);
      send_word(q[3], 1'b1);
      out_stream_tdata  = q[4];
      out_stream_tlast  = 1'b1;
      out_stream_tvalid = 1'b1;
      chk("bp_full_k_tready", 128'(out_stream_tready), 128'd0);
      chk("bp_full_ce", 128'(ce), 128'd0);
      step();
      chk("bp_full_hold", 128'(out_stream_tready), 128'd0);
      lii_out_p0_tready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_valid%0d", k), 128'(lii_out_p0_tvalid), 128'd1);
         chk($sformatf("bp_data%0d", k), lii_out_p0_tdata, 128'(q[k]));
         chk($sformatf("bp_keep%0d", k), 128'(lii_out_p0_tkeep), 128'h1);
         acc_now = out_stream_tvalid & out_stream_tready;
         step();
         if (acc_now) begin
            out_stream_tvalid = 1'b0;
            out_stream_tlast  = 1'b0;
         end
      end
      chk("bp_empty", 128'(lii_out_p0_tvalid), 128'd0);
      step();
      chk("bp_ce_back", 128'(ce), 128'd1);

      // asynchronous reset in the middle of traffic
      lii_out_p0_tready = 1'b0;
      lii_in_p0_tdata   = uv[2].data;
      lii_in_p0_dst     = 8'h00;
      lii_in_p0_tvalid  = 1'b1;
      wait_in_ready();
      step();
      lii_in_p0_tvalid = 1'b0;
      step();
      send_word(32'h0000A001, 1'b0);
      send_word(32'h0000A002, 1'b1);
      send_word(32'h0000A003, 1'b0);
      #1 arst = 1'b1;
      #1;
      chk("arst_in_stream_tvalid", 128'(in_stream_tvalid), 128'd0);
      chk("arst_out_tvalid", 128'(lii_out_p0_tvalid), 128'd0);
      chk("arst_in_tready", 128'(lii_in_p0_tready), 128'd0);
      chk("arst_k_tready", 128'(out_stream_tready), 128'd0);
      chk("arst_ce", 128'(ce), 128'd0);
      chk("arst_drop", 128'(drop_cnt), 128'd0);
      step();
      arst = 1'b0;
      step();
      step();
      chk("post_in_stream_tvalid", 128'(in_stream_tvalid), 128'd0);
      chk("post_out_tvalid", 128'(lii_out_p0_tvalid), 128'd0);
      lii_out_p0_tready = 1'b1;
      send_word(32'h0000B000, 1'b0);
      send_word(32'h0000B001, 1'b0);
      send_word(32'h0000B002, 1'b1);
      chk("post_valid", 128'(lii_out_p0_tvalid), 128'd1);
      chk("post_data", lii_out_p0_tdata, 128'h00000000_0000B002_0000B001_0000B000);
      chk("post_keep", 128'(lii_out_p0_tkeep), 128'h7);
      step();
      chk("post_drained", 128'(lii_out_p0_tvalid), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
